// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states and entry sizing.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned INSTR_W     = 32;

    function automatic int unsigned entry_width(input int unsigned xlen);
        return xlen + INSTR_W;
    endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Small synchronous FIFO of {pc, instr} pairs between fetch and decode.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter  int unsigned XLEN  = 64,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [XLEN-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output logic [XLEN-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned ENTRY_W = entry_width(XLEN);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign {head_pc, head_instr} = mem[rd_ptr];
    assign empty = (count == '0);

    // Flush wins over a same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_pc, push_instr};
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues one-at-a-time fetches to imem, buffers returned words for decode
// and applies branch redirects from execute.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t     state;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  redir_pc;
    logic [XLEN-1:0]  pc_next;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;
    logic             issue;
    logic             take;
    logic             push;
    logic             pop;

    assign redir_pc = redirect_pc & ~XLEN'(3);
    assign pc_next  = fetch_pc + XLEN'(INSTR_BYTES);

    // Issue only against the registered count so a push can never overflow the buffer.
    assign issue     = (state == S_REQ) && (buf_count < CNT_W'(BUF_DEPTH));
    assign imem_req  = issue || (state == S_WAIT) || (state == S_DISCARD);
    assign imem_addr = (state == S_WAIT || state == S_DISCARD) ? req_addr : fetch_pc;

    // An ack only carries usable data when it completes a live, non-discarded request.
    assign take      = imem_ack && (issue || state == S_WAIT);
    assign push      = take && !redirect_en;
    assign out_valid = !buf_empty && !redirect_en;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    if (redirect_en) fetch_pc <= redir_pc;
                end
                S_REQ: begin
                    req_addr <= fetch_pc;
                    if (redirect_en) begin
                        fetch_pc <= redir_pc;
                        state    <= (issue && !imem_ack) ? S_DISCARD : S_REQ;
                    end else if (issue) begin
                        if (imem_ack) fetch_pc <= pc_next;
                        else          state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_en) begin
                        fetch_pc <= redir_pc;
                        state    <= imem_ack ? S_REQ : S_DISCARD;
                    end else if (imem_ack) begin
                        fetch_pc <= pc_next;
                        state    <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (redirect_en) fetch_pc <= redir_pc;
                    if (imem_ack)    state    <= S_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fetch_ibuf #(
        .XLEN  (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_ibuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_en),
        .push_pc    (imem_addr),
        .push_instr (imem_rdata),
        .head_pc    (out_pc),
        .head_instr (out_instr),
        .empty      (buf_empty),
        .count      (buf_count)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector table, reset-during-request sequence and randomized run against a
// transaction-level model of the fetch sequencer.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.XLEN(64), .RESET_PC(64'h0), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [63:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] vpc;
        logic [31:0] vinstr;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic [63:0] rpc, input logic ack,
                                input logic [31:0] rdata, input logic rdy, input logic req,
                                input logic [63:0] addr, input logic valid,
                                input logic [63:0] vpc, input logic [31:0] vinstr);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.req = req; v.addr = addr; v.valid = valid; v.vpc = vpc; v.vinstr = vinstr;
        return v;
    endfunction

    // Reference model: pending-fetch bookkeeping plus a queue of buffered words.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_oaddr;
    bit          m_out;
    bit          m_drop;
    bit          m_started;

    task automatic model_reset();
        m_q.delete();
        m_pc = 64'h0; m_oaddr = 64'h0;
        m_out = 0; m_drop = 0; m_started = 0;
    endtask

    task automatic model_cycle();
        bit          exp_req, exp_valid, accepted;
        logic [63:0] exp_addr;
        exp_req   = m_out || (m_started && m_q.size() < 2);
        exp_addr  = m_out ? m_oaddr : m_pc;
        exp_valid = (m_q.size() > 0) && !redirect_en;
        chk("rnd_req", 64'(imem_req), 64'(exp_req));
        chk("rnd_addr", imem_addr, exp_addr);
        chk("rnd_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("rnd_pc", out_pc, m_q[0].pc);
            chk("rnd_instr", 64'(out_instr), 64'(m_q[0].instr));
        end
        accepted = exp_req && imem_ack;
        m_out = exp_req && !imem_ack;
        if (m_out) m_oaddr = exp_addr;
        if (redirect_en) begin
            m_q.delete();
            m_pc   = redirect_pc & ~64'd3;
            m_drop = m_out;
        end else begin
            if (exp_valid && out_ready) void'(m_q.pop_front());
            if (accepted && !m_drop) begin
                m_q.push_back('{pc: exp_addr, instr: imem_rdata});
                m_pc = m_pc + 64'd4;
            end
            if (accepted) m_drop = 0;
        end
        m_started = 1;
    endtask

    vec_t tbl[$];

    initial begin
        logic [63:0] r64;

        // c0 IDLE, c1-c3 zero-latency stream, c4-c7 three-cycle latency, c8-c10 redirect
        // while outstanding, c11-c12 redirect with same-cycle ack, c13-c19 fill with ready low.
        tbl.push_back(mk(0, 0,      0, 0,   1, 0, 64'h0,   0, 0,      0));
        tbl.push_back(mk(0, 0,      1, 'hA0, 1, 1, 64'h0,  0, 0,      0));
        tbl.push_back(mk(0, 0,      1, 'hA1, 1, 1, 64'h4,  1, 64'h0,  'hA0));
        tbl.push_back(mk(0, 0,      1, 'hA2, 1, 1, 64'h8,  1, 64'h4,  'hA1));
        tbl.push_back(mk(0, 0,      0, 0,   1, 1, 64'hC,   1, 64'h8,  'hA2));
        tbl.push_back(mk(0, 0,      0, 0,   1, 1, 64'hC,   0, 0,      0));
        tbl.push_back(mk(0, 0,      0, 0,   1, 1, 64'hC,   0, 0,      0));
        tbl.push_back(mk(0, 0,      1, 'hA3, 1, 1, 64'hC,  0, 0,      0));
        tbl.push_back(mk(0, 0,      0, 0,   1, 1, 64'h10,  1, 64'hC,  'hA3));
        tbl.push_back(mk(1, 'h25,   0, 0,   1, 1, 64'h10,  0, 0,      0));
        tbl.push_back(mk(0, 0,      1, 'hDEAD, 1, 1, 64'h10, 0, 0,    0));
        tbl.push_back(mk(0, 0,      1, 'hA4, 1, 1, 64'h24, 0, 0,      0));
        tbl.push_back(mk(1, 'h100,  1, 'hA5, 1, 1, 64'h28, 0, 0,      0));
        tbl.push_back(mk(0, 0,      0, 0,   0, 1, 64'h100, 0, 0,      0));
        tbl.push_back(mk(0, 0,      1, 'hA6, 0, 1, 64'h100, 0, 0,     0));
        tbl.push_back(mk(0, 0,      1, 'hA7, 0, 1, 64'h104, 1, 64'h100, 'hA6));
        tbl.push_back(mk(0, 0,      1, 'hBAD, 0, 0, 64'h108, 1, 64'h100, 'hA6));
        tbl.push_back(mk(0, 0,      0, 0,   1, 0, 64'h108, 1, 64'h100, 'hA6));
        tbl.push_back(mk(0, 0,      0, 0,   0, 1, 64'h108, 1, 64'h104, 'hA7));
        tbl.push_back(mk(0, 0,      0, 0,   0, 1, 64'h108, 1, 64'h104, 'hA7));

        // Reset values
        @(negedge clk);
        chk("rst_req", 64'(imem_req), 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_instr", 64'(out_instr), 64'h0);
        chk("rst_pc", out_pc, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            redirect_en = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            imem_ack    = tbl[i].ack;
            imem_rdata  = tbl[i].rdata;
            out_ready   = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), 64'(imem_req), 64'(tbl[i].req));
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].valid));
            if (tbl[i].valid) begin
                chk($sformatf("v%0d_pc", i), out_pc, tbl[i].vpc);
                chk($sformatf("v%0d_instr", i), 64'(out_instr), 64'(tbl[i].vinstr));
            end
            @(posedge clk); #1;
        end

        // Reset while a request is waiting, then a stale ack around release.
        redirect_en = 0; imem_ack = 0; out_ready = 1;
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(imem_req), 64'h0);
        chk("mid_rst_addr", imem_addr, 64'h0);
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_pc", out_pc, 64'h0);
        @(posedge clk); #1 imem_ack = 1'b1; imem_rdata = 32'hBEEF;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("stale_req", 64'(imem_req), 64'h0);
        chk("stale_valid", 64'(out_valid), 64'h0);
        @(posedge clk); #1 imem_ack = 1'b0;
        @(negedge clk);
        chk("resume_req", 64'(imem_req), 64'h1);
        chk("resume_addr", imem_addr, 64'h0);
        chk("resume_valid", 64'(out_valid), 64'h0);

        // Randomized run against the model
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("rnd_rst_req", 64'(imem_req), 64'h0);
                chk("rnd_rst_valid", 64'(out_valid), 64'h0);
                @(posedge clk); #1 rst_n = 1'b1;
                model_reset();
                continue;
            end
            redirect_en = ($urandom_range(0, 11) == 0);
            r64 = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) r64 = 64'hFFFF_FFFF_FFFF_FFE0 | {60'h0, r64[3:0]};
            redirect_pc = r64;
            imem_ack    = ($urandom_range(0, 2) != 0);
            imem_rdata  = $urandom();
            out_ready   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_cycle();
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
